// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial memory controller. It arbitrates instruction fetches
// and load/store requests onto an 8-bit RAM port. Each access moves one byte per
// cycle, little-endian. A load or fetch assembles the bytes into a zero-extended
// word. A store streams out the low N bytes of its write data.
// RAM read timing: the byte for the address driven in a cycle is captured on the
// rising edge that ends that cycle. So a read of N bytes reports done in cycle
// N+1 after the accept edge.
module mem_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        jmp_e,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_data,
  output logic        if_done,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [1:0]  mem_size,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_done,
  output logic [31:0] ram_a,
  output logic [7:0]  ram_dout,
  output logic        ram_wr,
  input  logic [7:0]  ram_din,
  output logic        if_stall_req,
  output logic        mem_stall_req
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IF_RD  = 2'd1,
    MEM_RD = 2'd2,
    MEM_WR = 2'd3
  } state_t;

  state_t      state;
  logic [2:0]  cnt;        // index of the byte currently on the RAM port
  logic [2:0]  last;       // index of the final byte, N-1
  logic [2:0]  cnt_nx;
  logic [31:0] wdata;      // store data latched at accept
  logic        wr_q;
  logic        if_done_q;
  logic        mem_done_q;

  // Index of the last byte for a given access size; 11 behaves like a word.
  function automatic logic [2:0] last_idx(input logic [1:0] size);
    case (size)
      2'b00:   return 3'd0;
      2'b01:   return 3'd1;
      default: return 3'd3;
    endcase
  endfunction

  assign cnt_nx = cnt + 3'd1;

  // NOTE: rdy gates the strobes combinationally. A frozen controller therefore
  // never writes the RAM or signals done, and the registered strobe reappears
  // unchanged once rdy returns.
  assign ram_wr        = wr_q & rdy;
  assign if_done       = if_done_q & rdy;
  assign mem_done      = mem_done_q & rdy;
  assign if_stall_req  = if_req & ~if_done;
  assign mem_stall_req = mem_req & ~mem_done;

  // Controller FSM. It owns the RAM port registers, the byte counter and the
  // assembled read data.
  // NOTE: state registers use non-blocking assignments only. Every flop sees
  // the pre-edge values of the others, so update order inside the block is
  // irrelevant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      last       <= '0;
      wdata      <= '0;
      ram_a      <= '0;
      ram_dout   <= '0;
      wr_q       <= 1'b0;
      if_data    <= '0;
      mem_rdata  <= '0;
      if_done_q  <= 1'b0;
      mem_done_q <= 1'b0;
    end else if (rdy) begin
      if_done_q  <= 1'b0;
      mem_done_q <= 1'b0;
      case (state)
        IDLE: begin
          // Skip the cycle in which a done pulse is shown, so the completing
          // request is not accepted a second time.
          if (!if_done_q && !mem_done_q) begin
            if (mem_req) begin
              ram_a <= mem_addr;
              cnt   <= '0;
              last  <= last_idx(mem_size);
              if (mem_we) begin
                state    <= MEM_WR;
                wdata    <= mem_wdata;
                ram_dout <= mem_wdata[7:0];
                wr_q     <= 1'b1;
              end else begin
                state     <= MEM_RD;
                mem_rdata <= '0;
              end
            end else if (if_req && !jmp_e) begin
              state   <= IF_RD;
              ram_a   <= if_addr;
              cnt     <= '0;
              last    <= 3'd3;
              if_data <= '0;
            end
          end
        end

        IF_RD: begin
          if (jmp_e) begin
            // Flushed fetch: drop it silently and keep ram_a where it was.
            state <= IDLE;
            cnt   <= '0;
          end else begin
            if_data[{cnt[1:0], 3'b000} +: 8] <= ram_din;
            if (cnt == last) begin
              state     <= IDLE;
              cnt       <= '0;
              if_done_q <= 1'b1;
            end else begin
              cnt   <= cnt_nx;
              ram_a <= ram_a + 32'd1;
            end
          end
        end

        MEM_RD: begin
          mem_rdata[{cnt[1:0], 3'b000} +: 8] <= ram_din;
          if (cnt == last) begin
            state      <= IDLE;
            cnt        <= '0;
            mem_done_q <= 1'b1;
          end else begin
            cnt   <= cnt_nx;
            ram_a <= ram_a + 32'd1;
          end
        end

        MEM_WR: begin
          if (cnt == last) begin
            state      <= IDLE;
            cnt        <= '0;
            wr_q       <= 1'b0;
            mem_done_q <= 1'b1;
          end else begin
            cnt      <= cnt_nx;
            ram_a    <= ram_a + 32'd1;
            ram_dout <= wdata[{cnt_nx[1:0], 3'b000} +: 8];
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: self-checking bench for mem_ctrl. A byte-wide RAM model sits on
// the RAM port. A transaction-level reference memory predicts every load, fetch
// and store. Directed vectors come from a table. Hand sequences cover conflict,
// flush, freeze and reset. Random transactions are checked against the model.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst, rdy, jmp_e;
  logic        if_req, mem_req, mem_we;
  logic [31:0] if_addr, mem_addr, mem_wdata;
  logic [1:0]  mem_size;
  logic [31:0] if_data, mem_rdata, ram_a;
  logic        if_done, mem_done, ram_wr, if_stall_req, mem_stall_req;
  logic [7:0]  ram_dout, ram_din;

  mem_ctrl dut (
    .clk(clk), .rst(rst), .rdy(rdy), .jmp_e(jmp_e),
    .if_req(if_req), .if_addr(if_addr), .if_data(if_data), .if_done(if_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_done(mem_done),
    .ram_a(ram_a), .ram_dout(ram_dout), .ram_wr(ram_wr), .ram_din(ram_din),
    .if_stall_req(if_stall_req), .mem_stall_req(mem_stall_req)
  );

  always #5 clk = ~clk;

  // RAM attached to the controller, plus a preload port for the bench.
  bit   [7:0] ram [0:1023];
  logic       poke_en;
  logic [9:0] poke_a;
  logic [7:0] poke_d;
  always @(posedge clk) begin
    if (poke_en)     ram[poke_a]     <= poke_d;
    else if (ram_wr) ram[ram_a[9:0]] <= ram_dout;
  end
  assign ram_din = ram[ram_a[9:0]];

  // Reference memory: what the RAM should hold after each transaction.
  bit [7:0] ref_mem [0:1023];

  typedef enum {K_FETCH, K_LOAD, K_STORE} kind_e;
  typedef struct {
    kind_e       kind;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    int          exp_lat;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int nbytes(input logic [1:0] size);
    return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a, input int n);
    logic [31:0] r;
    r = '0;
    for (int k = 0; k < n; k++) r = r | (32'(ref_mem[10'(a + 32'(k))]) << (8 * k));
    return r;
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input int n);
    for (int k = 0; k < n; k++) ref_mem[10'(a + 32'(k))] = 8'(d >> (8 * k));
  endtask

  task automatic poke(input logic [9:0] a, input logic [7:0] d);
    poke_en = 1'b1;
    poke_a  = a;
    poke_d  = d;
    ref_mem[a] = d;
    step();
    poke_en = 1'b0;
  endtask

  // Runs one transaction from an idle controller. It counts cycles from the
  // request to done and checks data, latency, address/byte trace and stall.
  // rdy is dropped for frz_len cycles starting at cycle frz_at.
  task automatic run_txn(input vec_t v, input int frz_at, input int frz_len, input string tag);
    int          n, lat, wr_seen, proto_err, stall_err;
    logic        got_done, stall;
    logic [31:0] data;
    n = (v.kind == K_FETCH) ? 4 : nbytes(v.size);
    if (v.kind == K_FETCH) begin
      if_req  = 1'b1;
      if_addr = v.addr;
    end else begin
      mem_req   = 1'b1;
      mem_we    = (v.kind == K_STORE);
      mem_size  = v.size;
      mem_addr  = v.addr;
      mem_wdata = v.wdata;
    end
    lat = 0; wr_seen = 0; proto_err = 0; stall_err = 0; got_done = 1'b0;
    #1;
    stall = (v.kind == K_FETCH) ? if_stall_req : mem_stall_req;
    if (stall !== 1'b1) stall_err++;
    while (!got_done && lat < 64) begin
      step();
      lat++;
      if (frz_len > 0 && lat == frz_at) rdy = 1'b0;
      if (frz_len > 0 && lat == frz_at + frz_len) rdy = 1'b1;
      #1;
      got_done = (v.kind == K_FETCH) ? if_done : mem_done;
      stall    = (v.kind == K_FETCH) ? if_stall_req : mem_stall_req;
      if (stall !== !got_done) stall_err++;
      if (ram_wr === 1'b1) wr_seen++;
      if (ram_wr === 1'b1 && rdy === 1'b0) proto_err++;
      if (v.kind != K_STORE && ram_wr === 1'b1) proto_err++;
      if (frz_len == 0 && !got_done && lat <= n) begin
        if (ram_a !== v.addr + 32'(lat - 1)) proto_err++;
        if (v.kind == K_STORE && ram_dout !== 8'(v.wdata >> (8 * (lat - 1)))) proto_err++;
      end
    end
    data = (v.kind == K_FETCH) ? if_data : mem_rdata;
    if_req  = 1'b0;
    mem_req = 1'b0;
    rdy     = 1'b1;
    check($sformatf("%s latency", tag), 32'(lat), 32'(v.exp_lat + frz_len));
    if (v.kind == K_STORE) check($sformatf("%s write count", tag), 32'(wr_seen), 32'(n));
    else                   check($sformatf("%s data", tag), data, v.exp_data);
    check($sformatf("%s port trace errors", tag), 32'(proto_err), 32'd0);
    check($sformatf("%s stall errors", tag), 32'(stall_err), 32'd0);
    step();
  endtask

  vec_t        tbl [11];
  vec_t        v;
  int          c, nm, ni, mem_cyc, if_cyc, st_err, nd, n, fl, bad_bytes;
  logic [31:0] md, idata;

  initial begin
    rst = 1'b1; rdy = 1'b1; jmp_e = 1'b0;
    if_req = 1'b0; if_addr = '0;
    mem_req = 1'b0; mem_we = 1'b0; mem_size = '0; mem_addr = '0; mem_wdata = '0;
    poke_en = 1'b0; poke_a = '0; poke_d = '0;
    #2 rst = 1'b0;
    step();

    // Reset values are held while reset is asserted.
    check("reset ram_a", ram_a, 32'd0);
    check("reset if_data", if_data, 32'd0);
    check("reset mem_rdata", mem_rdata, 32'd0);
    check("reset strobes {dout,wr,if_done,mem_done}",
          {21'd0, ram_dout, ram_wr, if_done, mem_done}, 32'd0);

    // Preload the RAM while the controller is held in reset.
    poke(10'h100, 8'h13); poke(10'h101, 8'h05); poke(10'h102, 8'h00); poke(10'h103, 8'h00);
    poke(10'h031, 8'h80);
    for (int a = 0; a < 256; a++) poke(10'(32'h200 + a), 8'($urandom));
    rst = 1'b1;
    step();

    // Directed vectors: kind, size, addr, wdata, expected data, expected latency.
    tbl[0]  = '{K_FETCH, 2'b10, 32'h100, 32'h0,        32'h00000513, 5};
    tbl[1]  = '{K_STORE, 2'b10, 32'h020, 32'hDEADBEEF, 32'h0,        5};
    tbl[2]  = '{K_LOAD,  2'b10, 32'h020, 32'h0,        32'hDEADBEEF, 5};
    tbl[3]  = '{K_LOAD,  2'b00, 32'h031, 32'h0,        32'h00000080, 2};
    tbl[4]  = '{K_LOAD,  2'b01, 32'h022, 32'h0,        32'h0000DEAD, 3};
    tbl[5]  = '{K_LOAD,  2'b00, 32'h023, 32'h0,        32'h000000DE, 2};
    tbl[6]  = '{K_STORE, 2'b00, 32'h024, 32'hFFFFFF5A, 32'h0,        2};
    tbl[7]  = '{K_STORE, 2'b01, 32'h026, 32'h12349876, 32'h0,        3};
    tbl[8]  = '{K_LOAD,  2'b11, 32'h024, 32'h0,        32'h9876005A, 5};
    tbl[9]  = '{K_FETCH, 2'b00, 32'h022, 32'h0,        32'h005ADEAD, 5};
    tbl[10] = '{K_LOAD,  2'b01, 32'h101, 32'h0,        32'h00000005, 3};
    for (int i = 0; i < 11; i++) begin
      run_txn(tbl[i], 0, 0, $sformatf("vec%0d", i));
      if (tbl[i].kind == K_STORE) model_write(tbl[i].addr, tbl[i].wdata, nbytes(tbl[i].size));
    end

    // Simultaneous requests: the load goes first, the fetch follows, and each
    // done pulses once.
    if_req = 1'b1; if_addr = 32'h100;
    mem_req = 1'b1; mem_we = 1'b0; mem_size = 2'b10; mem_addr = 32'h20;
    c = 0; nm = 0; ni = 0; mem_cyc = -1; if_cyc = -1; st_err = 0; md = '0; idata = '0;
    #1;
    while (c < 64) begin
      if (mem_done) begin nm++; mem_cyc = c; md = mem_rdata; mem_req = 1'b0; end
      if (if_done) begin ni++; if_cyc = c; idata = if_data; if_req = 1'b0; end
      else if (ni == 0 && if_stall_req !== 1'b1) st_err++;
      if (ni > 0 && c >= if_cyc + 3) break;
      step();
      c++;
    end
    check("conflict mem_done cycle", 32'(mem_cyc), 32'd5);
    check("conflict if_done cycle", 32'(if_cyc), 32'd11);
    check("conflict mem_done pulses", 32'(nm), 32'd1);
    check("conflict if_done pulses", 32'(ni), 32'd1);
    check("conflict mem_rdata", md, 32'hDEADBEEF);
    check("conflict if_data", idata, 32'h00000513);
    check("conflict if_stall gaps", 32'(st_err), 32'd0);
    mem_req = 1'b0; if_req = 1'b0;

    // A flush in the second fetch cycle aborts without a done pulse.
    if_req = 1'b1; if_addr = 32'h100;
    step(); step();
    jmp_e = 1'b1;
    step();
    jmp_e = 1'b0; if_req = 1'b0;
    check("flush ram_a held", ram_a, 32'h101);
    nd = 0;
    for (int i = 0; i < 8; i++) begin
      if (if_done === 1'b1) nd++;
      step();
    end
    check("flush if_done count", 32'(nd), 32'd0);

    // A flush in IDLE blocks fetch acceptance for as long as it is held.
    if_req = 1'b1; if_addr = 32'h100; jmp_e = 1'b1;
    step(); step();
    check("jmp idle no accept", ram_a, 32'h101);
    jmp_e = 1'b0;
    v = '{K_FETCH, 2'b10, 32'h100, 32'h0, 32'h00000513, 5};
    run_txn(v, 0, 0, "refetch");

    // A 3-cycle freeze mid-load (and mid-store) delays the result by 3 cycles.
    v = '{K_LOAD, 2'b10, 32'h020, 32'h0, 32'hDEADBEEF, 5};
    run_txn(v, 2, 3, "freeze load");
    v = '{K_STORE, 2'b10, 32'h028, 32'hCAFEF00D, 32'h0, 5};
    run_txn(v, 2, 3, "freeze store");
    model_write(32'h28, 32'hCAFEF00D, 4);
    v = '{K_LOAD, 2'b10, 32'h028, 32'h0, 32'hCAFEF00D, 5};
    run_txn(v, 0, 0, "after freeze");

    // Reset during a store clears the outputs at once and suppresses mem_done.
    // Only byte 0 has been written by then.
    mem_req = 1'b1; mem_we = 1'b1; mem_size = 2'b10; mem_addr = 32'h40; mem_wdata = 32'h11223344;
    step(); step();
    rst = 1'b0;
    #1;
    check("async rst ram_a", ram_a, 32'd0);
    check("async rst data", if_data | mem_rdata, 32'd0);
    check("async rst strobes", {21'd0, ram_dout, ram_wr, if_done, mem_done}, 32'd0);
    mem_req = 1'b0; mem_we = 1'b0;
    step(); step();
    rst = 1'b1;
    nd = 0;
    for (int i = 0; i < 6; i++) begin
      if (mem_done === 1'b1) nd++;
      step();
    end
    check("rst mid-store mem_done count", 32'(nd), 32'd0);
    model_write(32'h40, 32'h44, 1);
    v = '{K_LOAD, 2'b10, 32'h040, 32'h0, 32'h00000044, 5};
    run_txn(v, 0, 0, "partial store");

    // Random traffic against the reference memory, with occasional freezes.
    for (int i = 0; i < 40; i++) begin
      v.kind  = kind_e'($urandom_range(0, 2));
      v.size  = 2'($urandom_range(0, 3));
      v.addr  = 32'h200 + 32'($urandom_range(0, 252));
      v.wdata = $urandom;
      n = (v.kind == K_FETCH) ? 4 : nbytes(v.size);
      v.exp_data = model_read(v.addr, n);
      v.exp_lat  = n + 1;
      fl = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 3)) : 0;
      run_txn(v, 1, fl, $sformatf("rnd%0d", i));
      if (v.kind == K_STORE) model_write(v.addr, v.wdata, n);
    end

    // Final RAM image must match the reference memory byte for byte.
    bad_bytes = 0;
    for (int a = 0; a < 1024; a++) if (ram[a] != ref_mem[a]) bad_bytes++;
    check("ram image mismatched bytes", 32'(bad_bytes), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, %0d compared", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule
